// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ack, presents a registered IF/ID word.
// Latency: imem_ack -> if_valid one cycle; one instruction per cycle with zero-wait ack.
// Backpressure: stall holds the IF/ID word; a fetch landing during stall parks in a one-entry skid.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction_code,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  ifid_t       skid_q, skid_d;
  ifid_t       out_q, out_d;
  logic        out_vld_q, out_vld_d;

  logic        out_free;
  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;
  ifid_t       fetched;

  assign redir_tgt = redirect_pc & ~32'd3;
  assign pc_inc    = pc_q + 32'd4;
  assign fetched   = '{instr: imem_rdata, pc: pc_q};
  assign out_free  = !out_vld_q || !stall;

  // In DROP the abandoned address stays on the bus until its ack arrives.
  assign imem_req         = !reset && ((state_q == FETCH) || (state_q == DROP));
  assign imem_addr        = pc_q;
  assign instruction_code = out_q.instr;
  assign if_pc            = out_q.pc;
  assign if_valid         = out_vld_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    skid_d    = skid_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;

    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            pc_d = redir_tgt;
          end else begin
            tgt_d   = redir_tgt;
            state_d = DROP;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (out_free) begin
            out_d     = fetched;
            out_vld_d = 1'b1;
          end else begin
            skid_d  = fetched;
            state_d = HOLD;
          end
        end else if (out_free) begin
          out_vld_d   = 1'b0;
          out_d.instr = NOP_INSTR;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = redir_tgt;
          state_d = FETCH;
        end else if (!stall) begin
          out_d     = skid_q;
          out_vld_d = 1'b1;
          state_d   = FETCH;
        end
      end

      DROP: begin
        // The latest redirect wins; an ack in the same cycle retires the stale fetch.
        if (redirect) begin
          if (imem_ack) begin
            pc_d    = redir_tgt;
            state_d = FETCH;
          end else begin
            tgt_d = redir_tgt;
          end
        end else if (imem_ack) begin
          pc_d    = tgt_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    if (redirect) begin
      out_vld_d   = 1'b0;
      out_d.instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      tgt_q     <= RESET_PC;
      skid_q    <= '0;
      out_q     <= '{instr: NOP_INSTR, pc: 32'h0};
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      skid_q    <= skid_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule
